// File: rtl/ctrl_strobe_decoder.sv
// Passive observer of the VeriRISC controller strobes: recovers the sequencer
// phase and instruction class, counts completions and flags protocol errors.
module ctrl_strobe_decoder #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic               load_ac,
  input  logic               mem_rd,
  input  logic               mem_wr,
  input  logic               inc_pc,
  input  logic               load_pc,
  input  logic               load_ir,
  input  logic               halt,
  output logic [2:0]         phase,
  output logic               locked,
  output logic [2:0]         op_class,
  output logic               instr_done,
  output logic               skip_taken,
  output logic [COUNT_W-1:0] instr_count,
  output logic               halted,
  output logic               violation,
  output logic [2:0]         viol_code
);

  typedef enum logic {SEEK = 1'b0, LOCKED = 1'b1} state_t;

  // strobe vector bit order: {load_ac, mem_rd, mem_wr, inc_pc, load_pc, load_ir, halt}
  localparam logic [6:0] P_NONE    = 7'b000_0000;
  localparam logic [6:0] P_RD      = 7'b010_0000;
  localparam logic [6:0] P_RD_IR   = 7'b010_0010;
  localparam logic [6:0] P_INC     = 7'b000_1000;
  localparam logic [6:0] P_INC_HLT = 7'b000_1001;
  localparam logic [6:0] P_RD_AC   = 7'b110_0000;
  localparam logic [6:0] P_PC      = 7'b000_0100;
  localparam logic [6:0] P_INC_PC  = 7'b000_1100;
  localparam logic [6:0] P_WR      = 7'b001_0000;

  localparam logic [2:0] C_HLT  = 3'd0;
  localparam logic [2:0] C_SKZ  = 3'd1;
  localparam logic [2:0] C_ALU  = 3'd2;
  localparam logic [2:0] C_STO  = 3'd3;
  localparam logic [2:0] C_JMP  = 3'd4;
  localparam logic [2:0] C_NONE = 3'd7;

  localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};
  localparam logic [COUNT_W-1:0] CNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

  function automatic logic [2:0] phase_code(input logic [2:0] p);
    if (p <= 3'd3) begin
      return 3'd1;
    end else begin
      return p - 3'd2;
    end
  endfunction

  logic [6:0]         strobe_s;
  logic [2:0]         exp_phase_s;
  logic               match_s;
  logic [2:0]         cls_s;
  logic               skip_s;
  state_t             state_r, state_s;
  logic               prev_fetch_r, prev_fetch_s;
  logic               hlt_r, hlt_s, alu_r, alu_s, skz_r, skz_s, jmp_r, jmp_s;
  logic [2:0]         phase_r, phase_s;
  logic               locked_r, locked_s;
  logic [2:0]         op_class_r, op_class_s;
  logic               instr_done_r, instr_done_s;
  logic               skip_taken_r, skip_taken_s;
  logic [COUNT_W-1:0] count_r, count_s;
  logic               halted_r, halted_s;
  logic               violation_r, violation_s;
  logic [2:0]         viol_code_r, viol_code_s;

  assign strobe_s = {load_ac, mem_rd, mem_wr, inc_pc, load_pc, load_ir, halt};

  // Pattern check of the sample against the expected phase, then next-state selection
  always_comb begin
    exp_phase_s = phase_r + 3'd1;
    match_s     = 1'b0;
    cls_s       = C_NONE;
    skip_s      = 1'b0;
    hlt_s       = hlt_r;
    alu_s       = alu_r;
    skz_s       = skz_r;
    jmp_s       = jmp_r;
    case (exp_phase_s)
      3'd0: match_s = (strobe_s == P_NONE);
      3'd1: match_s = (strobe_s == P_RD);
      3'd2, 3'd3: match_s = (strobe_s == P_RD_IR);
      3'd4: begin
        match_s = (strobe_s == P_INC) || (strobe_s == P_INC_HLT);
        hlt_s   = strobe_s[0];
      end
      3'd5: begin
        if (hlt_r) begin
          match_s = (strobe_s == P_NONE);
        end else begin
          match_s = (strobe_s == P_RD) || (strobe_s == P_NONE);
          alu_s   = (strobe_s == P_RD);
        end
      end
      3'd6: begin
        if (alu_r) begin
          match_s = (strobe_s == P_RD_AC);
        end else if (hlt_r) begin
          match_s = (strobe_s == P_NONE);
        end else begin
          match_s = (strobe_s == P_NONE) || (strobe_s == P_INC) || (strobe_s == P_PC);
          skz_s   = (strobe_s == P_INC);
          jmp_s   = (strobe_s == P_PC);
        end
      end
      3'd7: begin
        if (alu_r) begin
          match_s = (strobe_s == P_RD_AC);
          cls_s   = C_ALU;
        end else if (hlt_r) begin
          match_s = (strobe_s == P_NONE);
          cls_s   = C_HLT;
        end else if (jmp_r) begin
          match_s = (strobe_s == P_INC_PC);
          cls_s   = C_JMP;
        end else if (skz_r) begin
          match_s = (strobe_s == P_NONE);
          cls_s   = C_SKZ;
          skip_s  = 1'b1;
        end else begin
          match_s = (strobe_s == P_NONE) || (strobe_s == P_WR);
          if (strobe_s == P_WR) begin
            cls_s = C_STO;
          end else begin
            cls_s = C_SKZ;
          end
        end
      end
      default: match_s = 1'b0;
    endcase

    state_s      = state_r;
    prev_fetch_s = prev_fetch_r;
    phase_s      = phase_r;
    locked_s     = locked_r;
    op_class_s   = op_class_r;
    instr_done_s = 1'b0;
    skip_taken_s = skip_taken_r;
    count_s      = count_r;
    halted_s     = halted_r;
    violation_s  = 1'b0;
    viol_code_s  = viol_code_r;

    // bus contention outranks every other check, even while seeking
    if (strobe_s[5] && strobe_s[4]) begin
      state_s      = SEEK;
      prev_fetch_s = 1'b0;
      phase_s      = 3'd0;
      locked_s     = 1'b0;
      violation_s  = 1'b1;
      viol_code_s  = 3'd6;
      {hlt_s, alu_s, skz_s, jmp_s} = 4'b0000;
    end else if (state_r == SEEK) begin
      {hlt_s, alu_s, skz_s, jmp_s} = 4'b0000;
      if (prev_fetch_r && (strobe_s == P_RD_IR)) begin
        state_s      = LOCKED;
        prev_fetch_s = 1'b0;
        phase_s      = 3'd2;
        locked_s     = 1'b1;
      end else begin
        prev_fetch_s = (strobe_s == P_RD);
      end
    end else if (!match_s) begin
      state_s      = SEEK;
      prev_fetch_s = 1'b0;
      phase_s      = 3'd0;
      locked_s     = 1'b0;
      violation_s  = 1'b1;
      viol_code_s  = phase_code(exp_phase_s);
      {hlt_s, alu_s, skz_s, jmp_s} = 4'b0000;
    end else begin
      phase_s = exp_phase_s;
      if (exp_phase_s == 3'd7) begin
        instr_done_s = 1'b1;
        op_class_s   = cls_s;
        skip_taken_s = skip_s;
        halted_s     = halted_r | (cls_s == C_HLT);
        if (count_r != CNT_MAX) begin
          count_s = count_r + CNT_ONE;
        end else begin
          count_s = count_r;
        end
        {hlt_s, alu_s, skz_s, jmp_s} = 4'b0000;
      end else begin
        instr_done_s = 1'b0;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_r      <= SEEK;
      prev_fetch_r <= 1'b0;
      hlt_r        <= 1'b0;
      alu_r        <= 1'b0;
      skz_r        <= 1'b0;
      jmp_r        <= 1'b0;
      phase_r      <= 3'd0;
      locked_r     <= 1'b0;
      op_class_r   <= C_NONE;
      instr_done_r <= 1'b0;
      skip_taken_r <= 1'b0;
      count_r      <= {COUNT_W{1'b0}};
      halted_r     <= 1'b0;
      violation_r  <= 1'b0;
      viol_code_r  <= 3'd0;
    end else begin
      state_r      <= state_s;
      prev_fetch_r <= prev_fetch_s;
      hlt_r        <= hlt_s;
      alu_r        <= alu_s;
      skz_r        <= skz_s;
      jmp_r        <= jmp_s;
      phase_r      <= phase_s;
      locked_r     <= locked_s;
      op_class_r   <= op_class_s;
      instr_done_r <= instr_done_s;
      skip_taken_r <= skip_taken_s;
      count_r      <= count_s;
      halted_r     <= halted_s;
      violation_r  <= violation_s;
      viol_code_r  <= viol_code_s;
    end
  end

  assign phase       = phase_r;
  assign locked      = locked_r;
  assign op_class    = op_class_r;
  assign instr_done  = instr_done_r;
  assign skip_taken  = skip_taken_r;
  assign instr_count = count_r;
  assign halted      = halted_r;
  assign violation   = violation_r;
  assign viol_code   = viol_code_r;

endmodule

// File: tb/tb_ctrl_strobe_decoder.sv
// Randomized bench for ctrl_strobe_decoder; the reference model matches observed
// samples against a table of complete legal 8-sample instruction sequences.
module tb_ctrl_strobe_decoder;

  logic        clk = 1'b0;
  logic        rst_ = 1'b0;
  logic [6:0]  drv = 7'd0;   // {load_ac, mem_rd, mem_wr, inc_pc, load_pc, load_ir, halt}

  logic [2:0]  phase, op_class, viol_code;
  logic        locked, instr_done, skip_taken, halted, violation;
  logic [15:0] instr_count;
  logic [2:0]  phase2, op_class2, viol_code2;
  logic        locked2, instr_done2, skip_taken2, halted2, violation2;
  logic [1:0]  instr_count2;

  ctrl_strobe_decoder #(.COUNT_W(16)) dut (
    .clk(clk), .rst_(rst_),
    .load_ac(drv[6]), .mem_rd(drv[5]), .mem_wr(drv[4]), .inc_pc(drv[3]),
    .load_pc(drv[2]), .load_ir(drv[1]), .halt(drv[0]),
    .phase(phase), .locked(locked), .op_class(op_class), .instr_done(instr_done),
    .skip_taken(skip_taken), .instr_count(instr_count), .halted(halted),
    .violation(violation), .viol_code(viol_code)
  );

  ctrl_strobe_decoder #(.COUNT_W(2)) dut2 (
    .clk(clk), .rst_(rst_),
    .load_ac(drv[6]), .mem_rd(drv[5]), .mem_wr(drv[4]), .inc_pc(drv[3]),
    .load_pc(drv[2]), .load_ir(drv[1]), .halt(drv[0]),
    .phase(phase2), .locked(locked2), .op_class(op_class2), .instr_done(instr_done2),
    .skip_taken(skip_taken2), .instr_count(instr_count2), .halted(halted2),
    .violation(violation2), .viol_code(viol_code2)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] S0     = 7'b000_0000;
  localparam logic [6:0] RD     = 7'b010_0000;
  localparam logic [6:0] RD_IR  = 7'b010_0010;
  localparam logic [6:0] INC    = 7'b000_1000;
  localparam logic [6:0] INC_H  = 7'b000_1001;
  localparam logic [6:0] RD_AC  = 7'b110_0000;
  localparam logic [6:0] PC     = 7'b000_0100;
  localparam logic [6:0] INC_PC = 7'b000_1100;
  localparam logic [6:0] WR     = 7'b001_0000;

  // rows: 0 ALU, 1 HLT, 2 SKZ not taken, 3 SKZ taken, 4 STO, 5 JMP
  logic [6:0] seq [6][8];
  int         row_cls  [6] = '{2, 0, 1, 1, 3, 4};
  int         row_skip [6] = '{0, 0, 0, 1, 0, 0};

  int         n_checks = 0;
  int         n_errs   = 0;

  logic [6:0] hist [8];
  bit         m_locked, m_prev, m_done, m_viol, m_skip, m_halted;
  int         m_phase, m_class, m_code, m_cnt, m_cnt2;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0; m_prev = 1'b0; m_done = 1'b0; m_viol = 1'b0; m_skip = 1'b0;
    m_halted = 1'b0; m_phase = 0; m_class = 7; m_code = 0; m_cnt = 0; m_cnt2 = 0;
  endtask

  task automatic model_violate(input int code);
    m_viol = 1'b1; m_code = code; m_locked = 1'b0; m_phase = 0; m_prev = 1'b0;
  endtask

  task automatic model_step(input logic [6:0] v);
    int pos, hit;
    bit ok;
    m_done = 1'b0;
    m_viol = 1'b0;
    if (v[5] && v[4]) begin
      model_violate(6);
    end else if (!m_locked) begin
      if (m_prev && v == RD_IR) begin
        m_locked = 1'b1; m_phase = 2; m_prev = 1'b0;
        hist[0] = S0; hist[1] = RD; hist[2] = RD_IR;
      end else begin
        m_prev = (v == RD);
      end
    end else begin
      pos = (m_phase + 1) % 8;
      hist[pos] = v;
      hit = -1;
      for (int r = 0; r < 6; r++) begin
        ok = 1'b1;
        for (int i = 0; i <= pos; i++) if (hist[i] != seq[r][i]) ok = 1'b0;
        if (ok && hit < 0) hit = r;
      end
      if (hit < 0) begin
        model_violate(pos <= 3 ? 1 : pos - 2);
      end else begin
        m_phase = pos;
        if (pos == 7) begin
          m_done = 1'b1;
          m_class = row_cls[hit];
          m_skip = (row_skip[hit] != 0);
          if (m_class == 0) m_halted = 1'b1;
          if (m_cnt < 65535) m_cnt++;
          if (m_cnt2 < 3) m_cnt2++;
        end
      end
    end
  endtask

  task automatic check_outputs();
    check_val("phase", phase, m_phase);
    check_val("locked", locked, m_locked);
    check_val("op_class", op_class, m_class);
    check_val("instr_done", instr_done, m_done);
    check_val("skip_taken", skip_taken, m_skip);
    check_val("instr_count", instr_count, m_cnt);
    check_val("halted", halted, m_halted);
    check_val("violation", violation, m_viol);
    check_val("viol_code", viol_code, m_code);
    check_val("count_w2", instr_count2, m_cnt2);
    check_val("locked_w2", locked2, m_locked);
  endtask

  task automatic apply(input logic [6:0] v);
    @(negedge clk);
    drv = v;
    @(posedge clk);
    model_step(v);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_ = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    rst_ = 1'b1;
    drv = S0;
    @(posedge clk);
    model_step(S0);
    #1;
    check_outputs();
  endtask

  task automatic run_instr(input int row, input int err_pct, input int rst_at);
    logic [6:0] v;
    for (int p = 0; p < 8; p++) begin
      if (p == rst_at) do_reset();
      v = seq[row][p];
      if (int'($urandom_range(99)) < err_pct) v = 7'($urandom);
      apply(v);
    end
  endtask

  initial begin
    for (int r = 0; r < 6; r++) begin
      seq[r][0] = S0; seq[r][1] = RD; seq[r][2] = RD_IR; seq[r][3] = RD_IR;
      seq[r][4] = INC; seq[r][5] = S0; seq[r][6] = S0; seq[r][7] = S0;
    end
    seq[0][5] = RD; seq[0][6] = RD_AC; seq[0][7] = RD_AC;
    seq[1][4] = INC_H;
    seq[3][6] = INC;
    seq[4][7] = WR;
    seq[5][6] = PC; seq[5][7] = INC_PC;

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    rst_ = 1'b1;

    // directed: LDA, JMP, STO, SKZ taken, SKZ not taken, HLT, ALU
    run_instr(0, 0, -1);
    check_val("lda_class", op_class, 3'd2);
    check_val("lda_count", instr_count, 16'd1);
    run_instr(5, 0, -1);
    run_instr(4, 0, -1);
    run_instr(3, 0, -1);
    run_instr(2, 0, -1);
    run_instr(1, 0, -1);
    run_instr(0, 0, -1);
    check_val("halt_sticky", halted, 1'b1);
    check_val("count_7", instr_count, 16'd7);
    check_val("count_w2_sat", instr_count2, 2'd3);

    // phase-5 mem_wr violation, then relock
    for (int p = 0; p < 5; p++) apply(seq[0][p]);
    apply(WR);
    check_val("p5_code", viol_code, 3'd3);
    run_instr(4, 0, -1);
    // contention while seeking
    apply(7'b011_0000);
    apply(S0);
    apply(7'b011_0000);
    check_val("seek_code", viol_code, 3'd6);
    // reset during phase 6
    run_instr(0, 0, 6);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(9) == 0) begin
        for (int k = 0; k <= int'($urandom_range(2)); k++) apply(7'($urandom));
      end
      run_instr(int'($urandom_range(5)), 4,
                ($urandom_range(49) == 0) ? int'($urandom_range(7)) : -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
    $finish;
  end

endmodule
